// File: rtl/usbdev_aon_suspend_seq_pkg.sv
// Shared types and constants for the AON suspend/resume sequencer.
package usbdev_aon_suspend_seq_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSuspReq = 3'd1,
        StActive  = 3'd2,
        StWake    = 3'd3,
        StAck     = 3'd4
    } aon_seq_state_e;

    // Bit positions inside cause_o
    localparam int unsigned CauseNotIdle   = 0;
    localparam int unsigned CauseBusReset  = 1;
    localparam int unsigned CauseSenseLost = 2;

endpackage

// File: rtl/usbdev_aon_suspend_seq_if.sv
// Command, detector and status signals between the AON sequencer and its environment.
interface usbdev_aon_suspend_seq_if;

    logic       suspend_cmd_aon_i;
    logic       resume_cmd_aon_i;
    logic       err_clr_aon_i;
    logic       wake_detect_active_i;
    logic       wake_req_aon_i;
    logic       bus_not_idle_aon_i;
    logic       bus_reset_aon_i;
    logic       sense_lost_aon_i;
    logic       suspend_req_aon_o;
    logic       wake_ack_aon_o;
    logic       wake_pending_o;
    logic [2:0] cause_o;
    logic       cause_valid_o;
    logic       timeout_err_o;
    logic [2:0] state_o;

    // Sequencer side
    modport master (
        input  suspend_cmd_aon_i, resume_cmd_aon_i, err_clr_aon_i,
        input  wake_detect_active_i, wake_req_aon_i,
        input  bus_not_idle_aon_i, bus_reset_aon_i, sense_lost_aon_i,
        output suspend_req_aon_o, wake_ack_aon_o, wake_pending_o,
        output cause_o, cause_valid_o, timeout_err_o, state_o
    );

    // Register block / wake detector side
    modport slave (
        output suspend_cmd_aon_i, resume_cmd_aon_i, err_clr_aon_i,
        output wake_detect_active_i, wake_req_aon_i,
        output bus_not_idle_aon_i, bus_reset_aon_i, sense_lost_aon_i,
        input  suspend_req_aon_o, wake_ack_aon_o, wake_pending_o,
        input  cause_o, cause_valid_o, timeout_err_o, state_o
    );

endinterface

// File: rtl/usbdev_aon_suspend_seq.sv
// AON sequencer: turns sw suspend/resume pulses into the suspend_req / wake_ack
// handshake with the wake detector, with per-handshake timeout and wake-cause capture.
module usbdev_aon_suspend_seq
    import usbdev_aon_suspend_seq_pkg::*;
#(
    parameter int unsigned HsTimeout = 64
) (
    input  logic                           clk_aon_i,
    input  logic                           rst_aon_ni,
    usbdev_aon_suspend_seq_if.master       bus
);

    localparam int unsigned TimerW = $clog2(HsTimeout + 1);

    aon_seq_state_e    r_state;
    aon_seq_state_e    w_state_nxt;
    logic [TimerW-1:0] r_timer;
    logic              r_suspend_req;
    logic              r_wake_ack;
    logic              r_wake_pending;
    logic [2:0]        r_cause;
    logic              r_cause_valid;
    logic              r_timeout_err;

    logic              w_timeout;
    logic              w_set_err;
    logic              w_cause_clr;
    logic              w_cause_cap;

    assign w_timeout = (r_timer == TimerW'(HsTimeout - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_set_err   = 1'b0;
        w_cause_clr = 1'b0;
        w_cause_cap = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.suspend_cmd_aon_i) begin
                    w_state_nxt = StSuspReq;
                    w_cause_clr = 1'b1;
                end
            end
            StSuspReq: begin
                if (bus.wake_detect_active_i) begin
                    w_state_nxt = StActive;
                end else if (w_timeout) begin
                    w_state_nxt = StIdle;
                    w_set_err   = 1'b1;
                end
            end
            StActive: begin
                // A sw abort in the same cycle as a wake still records the cause
                if (bus.wake_req_aon_i) begin
                    w_cause_cap = 1'b1;
                    w_state_nxt = bus.resume_cmd_aon_i ? StAck : StWake;
                end else if (bus.resume_cmd_aon_i) begin
                    w_state_nxt = StAck;
                end else if (!bus.wake_detect_active_i) begin
                    w_state_nxt = StIdle;
                    w_set_err   = 1'b1;
                end
            end
            StWake: begin
                if (bus.resume_cmd_aon_i) begin
                    w_state_nxt = StAck;
                end
            end
            StAck: begin
                if (!bus.wake_detect_active_i) begin
                    w_state_nxt = StIdle;
                end else if (w_timeout) begin
                    w_state_nxt = StIdle;
                    w_set_err   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Outputs decode the next state so they line up with state_o after each edge
    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            r_state        <= StIdle;
            r_suspend_req  <= 1'b0;
            r_wake_ack     <= 1'b0;
            r_wake_pending <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_suspend_req  <= (w_state_nxt == StSuspReq);
            r_wake_ack     <= (w_state_nxt == StAck);
            r_wake_pending <= (w_state_nxt == StWake);
        end
    end

    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            r_timer <= '0;
        end else if (w_state_nxt != r_state) begin
            r_timer <= '0;
        end else if (r_timer != TimerW'(HsTimeout)) begin
            r_timer <= r_timer + TimerW'(1);
        end
    end

    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            r_cause       <= '0;
            r_cause_valid <= 1'b0;
        end else if (w_cause_clr) begin
            r_cause       <= '0;
            r_cause_valid <= 1'b0;
        end else if (w_cause_cap) begin
            r_cause[CauseNotIdle]   <= bus.bus_not_idle_aon_i;
            r_cause[CauseBusReset]  <= bus.bus_reset_aon_i;
            r_cause[CauseSenseLost] <= bus.sense_lost_aon_i;
            r_cause_valid           <= 1'b1;
        end
    end

    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            r_timeout_err <= 1'b0;
        end else if (w_set_err) begin
            r_timeout_err <= 1'b1;
        end else if (bus.err_clr_aon_i) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign bus.suspend_req_aon_o = r_suspend_req;
    assign bus.wake_ack_aon_o    = r_wake_ack;
    assign bus.wake_pending_o    = r_wake_pending;
    assign bus.cause_o           = r_cause;
    assign bus.cause_valid_o     = r_cause_valid;
    assign bus.timeout_err_o     = r_timeout_err;
    assign bus.state_o           = r_state;

    a_req_ack_exclusive: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
        !(r_suspend_req && r_wake_ack));

    a_outputs_known: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
        !$isunknown({r_suspend_req, r_wake_ack, r_wake_pending, r_cause,
                     r_cause_valid, r_timeout_err, r_state}));

    a_state_legal: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
        r_state inside {StIdle, StSuspReq, StActive, StWake, StAck});

endmodule
